im_fold_reader: RTL and testbench

- Read-side sequencer for the folded item-memory SRAM bank (FOLD_WIDTH-wide, single-port, 1-cycle read latency).
- Accepts a command of (base address, fold count) and issues one SRAM read per cycle.
- Captures each returned fold and streams it to the downstream HDC encoder over a valid/ready handshake, with full backpressure support.
- Sits between the encoder control and the memory wrapper, and drives the wrapper's address and write-enable pins.

---
 rtl/im_reader_pkg.sv | 34 +++
 rtl/im_fold_fifo2.sv | 63 ++++++
 rtl/im_fold_reader.sv | 158 +++++++++++++++
 tb/tb_im_fold_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/im_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_reader_pkg
// Description : Shared types and default constants for the folded item-memory
//               read sequencer (state encoding, output entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
package im_reader_pkg;

  localparam int c_DEF_FOLD_WIDTH      = 500;
  localparam int c_DEF_SRAM_ADDR_WIDTH = 10;
  localparam int c_DEF_SRAM_DEPTH      = 864;
  localparam int c_DEF_CNT_WIDTH       = 11;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Output FIFO entry at the default widths; the top packs the same field
  // order into a flat vector so the widths can follow its parameters.
  typedef struct packed {
    logic [c_DEF_FOLD_WIDTH-1:0] data;
    logic [c_DEF_CNT_WIDTH-1:0]  idx;
    logic                        last;
`ifdef IM_FOLD_PARITY_EN
    logic                        parity;
`endif
  } fold_entry_t;

endpackage
`default_nettype wire

// File: rtl/im_fold_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : im_fold_fifo2
// Description : Two-entry registered FIFO with occupancy output. Supports a
//               push and a pop in the same cycle, including when full.
// Revision    : 1.0 - initial release
// ============================================================================
module im_fold_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             w_do_pop;
  logic             w_do_push;

  // A pop frees a slot in the same cycle, so push-while-full is allowed with it.
  assign w_do_pop  = pop_i && (count_q != 2'd0);
  assign w_do_push = push_i && ((count_q != 2'd2) || w_do_pop);

  // Storage entries; each writes only when the write pointer selects it
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (w_do_push && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_do_push) wr_ptr_q <= ~wr_ptr_q;
      if (w_do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/im_fold_reader.sv
`default_nettype none
// ============================================================================
// Module      : im_fold_reader
// Description : Read sequencer for the folded item-memory SRAM. Takes a
//               (base, count) command, issues one read per cycle with
//               wrap-around addressing, and streams the returned folds over a
//               valid/ready interface through a 2-entry credit-managed FIFO.
//               Optional macro IM_FOLD_PARITY_EN adds a fold_parity output
//               (XOR-reduce of the fold, stored with each entry).
// Revision    : 1.0 - initial release
// ============================================================================
module im_fold_reader
  import im_reader_pkg::*;
#(
  parameter int FOLD_WIDTH      = c_DEF_FOLD_WIDTH,
  parameter int SRAM_ADDR_WIDTH = c_DEF_SRAM_ADDR_WIDTH,
  parameter int SRAM_DEPTH      = c_DEF_SRAM_DEPTH,
  parameter int CNT_WIDTH       = c_DEF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [CNT_WIDTH-1:0]       cmd_num_folds,
  output logic [SRAM_ADDR_WIDTH-1:0] im_addr,
  output logic                       we,
  input  logic [FOLD_WIDTH-1:0]      im_dout,
  output logic                       fold_valid,
  input  logic                       fold_ready,
  output logic [FOLD_WIDTH-1:0]      fold_data,
  output logic [CNT_WIDTH-1:0]       fold_idx,
  output logic                       fold_last,
`ifdef IM_FOLD_PARITY_EN
  output logic                       fold_parity,
`endif
  output logic                       busy
);

`ifdef IM_FOLD_PARITY_EN
  localparam int c_PAR_W = 1;
`else
  localparam int c_PAR_W = 0;
`endif
  localparam int                         c_ENTRY_W   = FOLD_WIDTH + CNT_WIDTH + 1 + c_PAR_W;
  localparam logic [SRAM_ADDR_WIDTH-1:0] c_DEPTH_A   = SRAM_ADDR_WIDTH'(SRAM_DEPTH);
  localparam logic [SRAM_ADDR_WIDTH-1:0] c_LAST_ADDR = SRAM_ADDR_WIDTH'(SRAM_DEPTH - 1);

  rd_state_e                  state_q, state_d;
  logic                       ready_q;
  logic                       in_flight_q;
  logic [SRAM_ADDR_WIDTH-1:0] next_addr_q;
  logic [SRAM_ADDR_WIDTH-1:0] addr_hold_q;
  logic [CNT_WIDTH-1:0]       num_q;
  logic [CNT_WIDTH-1:0]       issue_cnt_q;
  logic [CNT_WIDTH-1:0]       cap_idx_q;

  logic                       w_accept;
  logic                       w_pop;
  logic                       w_credit;
  logic                       w_issue;
  logic                       w_last_issue;
  logic [SRAM_ADDR_WIDTH-1:0] w_base_wrapped;
  logic [SRAM_ADDR_WIDTH-1:0] w_addr_next;
  logic [1:0]                 w_fifo_count;
  logic [c_ENTRY_W-1:0]       w_push_entry;
  logic [c_ENTRY_W-1:0]       w_head;

  assign w_accept = cmd_valid && ready_q;
  assign w_pop    = fold_valid && fold_ready;

  // Occupancy plus the read in flight must stay below 2 after this cycle's pop,
  // which is what makes overflow impossible under any backpressure.
  assign w_credit     = ({1'b0, w_fifo_count} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, w_pop});
  assign w_issue      = (state_q == ISSUE) && w_credit;
  assign w_last_issue = issue_cnt_q == (num_q - 1'b1);

  // Wrap addresses without a divider: single compare/subtract on the base,
  // compare-to-last on the increment.
  assign w_base_wrapped = (cmd_base_addr >= c_DEPTH_A) ? (cmd_base_addr - c_DEPTH_A) : cmd_base_addr;
  assign w_addr_next    = (next_addr_q == c_LAST_ADDR) ? '0 : (next_addr_q + 1'b1);

  // Address is live only on an issuing cycle; otherwise the last one is held.
  assign im_addr   = w_issue ? next_addr_q : addr_hold_q;
  assign we        = 1'b1;
  assign cmd_ready = ready_q;
  assign busy      = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept && (cmd_num_folds != '0)) state_d = ISSUE;
      ISSUE:   if (w_issue && w_last_issue)           state_d = DRAIN;
      DRAIN:   if (w_pop && fold_last)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, issue/capture counters, read-in-flight tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      in_flight_q <= 1'b0;
      next_addr_q <= '0;
      addr_hold_q <= '0;
      num_q       <= '0;
      issue_cnt_q <= '0;
      cap_idx_q   <= '0;
    end else begin
      ready_q     <= (state_d == IDLE);
      in_flight_q <= w_issue;
      addr_hold_q <= im_addr;
      if (w_accept) begin
        next_addr_q <= w_base_wrapped;
        num_q       <= cmd_num_folds;
        issue_cnt_q <= '0;
        cap_idx_q   <= '0;
      end else begin
        if (w_issue) begin
          next_addr_q <= w_addr_next;
          issue_cnt_q <= issue_cnt_q + 1'b1;
        end
        if (in_flight_q) cap_idx_q <= cap_idx_q + 1'b1;
      end
    end
  end

`ifdef IM_FOLD_PARITY_EN
  assign w_push_entry = {im_dout, cap_idx_q, (cap_idx_q == (num_q - 1'b1)), ^im_dout};
  assign {fold_data, fold_idx, fold_last, fold_parity} = w_head;
`else
  assign w_push_entry = {im_dout, cap_idx_q, (cap_idx_q == (num_q - 1'b1))};
  assign {fold_data, fold_idx, fold_last} = w_head;
`endif

  assign fold_valid = (w_fifo_count != 2'd0);

  im_fold_fifo2 #(
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_flight_q),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_im_fold_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_im_fold_reader
// Description : Self-checking bench for im_fold_reader. SRAM model holds the
//               value k at address k, so each fold's data names its address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_fold_reader;

  localparam int FW    = 500;
  localparam int AW    = 10;
  localparam int DEPTH = 864;
  localparam int CW    = 11;

  typedef struct {
    string       name;
    logic [AW-1:0] base;
    logic [CW-1:0] num;
    logic [15:0] rdy_pat;
    int          exp_addr [8];
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [CW-1:0] cmd_num_folds = '0;
  logic [AW-1:0] im_addr;
  logic          we;
  logic [FW-1:0] im_dout = '0;
  logic          fold_valid;
  logic          fold_ready = 1'b0;
  logic [FW-1:0] fold_data;
  logic [CW-1:0] fold_idx;
  logic          fold_last;
  logic          busy;
`ifdef IM_FOLD_PARITY_EN
  logic          fold_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] mem [DEPTH];
  vec_t          vecs [7];

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency
  always @(posedge clk) im_dout <= mem[im_addr];

  im_fold_reader dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_addr (cmd_base_addr),
    .cmd_num_folds (cmd_num_folds),
    .im_addr       (im_addr),
    .we            (we),
    .im_dout       (im_dout),
    .fold_valid    (fold_valid),
    .fold_ready    (fold_ready),
    .fold_data     (fold_data),
    .fold_idx      (fold_idx),
    .fold_last     (fold_last),
`ifdef IM_FOLD_PARITY_EN
    .fold_parity   (fold_parity),
`endif
    .busy          (busy)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command and follow it to completion with the given ready pattern
  task automatic run_cmd(input vec_t v);
    int            got;
    bit            done;
    bit            prev_stall;
    logic [FW-1:0] pd;
    logic [CW-1:0] pi;
    logic          pl;
    int            first_hs;
    int            last_hs;
    got = 0; done = 0; prev_stall = 0; pd = '0; pi = '0; pl = 1'b0;
    first_hs = -1; last_hs = -1;
    @(negedge clk);
    check({v.name, " cmd_ready before"}, 512'(cmd_ready), 512'(1));
    cmd_valid     = 1'b1;
    cmd_base_addr = v.base;
    cmd_num_folds = v.num;
    fold_ready    = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        check({v.name, " busy after accept"}, 512'(busy), 512'(v.num != 0));
        if (v.num != 0) check({v.name, " first im_addr"}, 512'(im_addr), 512'(v.base));
      end
      if (v.rdy_pat == 16'hFFFF && v.num != 0 && cyc <= 3)
        check({v.name, " fold_valid latency"}, 512'(fold_valid), 512'(cyc == 3));
      if (prev_stall) begin
        check({v.name, " stall valid"}, 512'(fold_valid), 512'(1));
        check({v.name, " stall data"},  512'(fold_data),  512'(pd));
        check({v.name, " stall idx"},   512'(fold_idx),   512'(pi));
        check({v.name, " stall last"},  512'(fold_last),  512'(pl));
      end
      if (got == int'(v.num)) begin
        check({v.name, " cmd_ready after"}, 512'(cmd_ready), 512'(1));
        check({v.name, " busy after"},      512'(busy),      512'(0));
        check({v.name, " valid after"},     512'(fold_valid), 512'(0));
        done = 1;
      end else begin
        fold_ready = v.rdy_pat[(cyc - 1) % 16];
        if (fold_valid && fold_ready) begin
          check({v.name, " fold_data"}, 512'(fold_data), 512'(v.exp_addr[got]));
          check({v.name, " fold_idx"},  512'(fold_idx),  512'(got));
          check({v.name, " fold_last"}, 512'(fold_last), 512'(got == int'(v.num) - 1));
`ifdef IM_FOLD_PARITY_EN
          check({v.name, " fold_parity"}, 512'(fold_parity), 512'(^(FW'(v.exp_addr[got]))));
`endif
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          got++;
        end
        prev_stall = fold_valid && !fold_ready;
        pd = fold_data;
        pi = fold_idx;
        pl = fold_last;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: folds %0d of %0d", v.name, got, v.num);
    end else if (v.rdy_pat == 16'hFFFF && v.num != 0) begin
      check({v.name, " back-to-back"}, 512'(last_hs - first_hs), 512'(int'(v.num) - 1));
    end
    fold_ready = 1'b0;
  endtask

  initial begin
    vec_t v2;
    for (int k = 0; k < DEPTH; k++) mem[k] = FW'(k);

    vecs[0] = '{name:"stream",  base:10'd5,   num:11'd4, rdy_pat:16'hFFFF, exp_addr:'{5, 6, 7, 8, 0, 0, 0, 0}};
    vecs[1] = '{name:"wrap",    base:10'd862, num:11'd3, rdy_pat:16'hFFFF, exp_addr:'{862, 863, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{name:"bp",      base:10'd100, num:11'd6, rdy_pat:16'h9249, exp_addr:'{100, 101, 102, 103, 104, 105, 0, 0}};
    vecs[3] = '{name:"single",  base:10'd863, num:11'd1, rdy_pat:16'hFFFF, exp_addr:'{863, 0, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{name:"zero",    base:10'd0,   num:11'd0, rdy_pat:16'hFFFF, exp_addr:'{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[5] = '{name:"wrap_bp", base:10'd860, num:11'd7, rdy_pat:16'hB36D, exp_addr:'{860, 861, 862, 863, 0, 1, 2, 0}};
    vecs[6] = '{name:"parity",  base:10'd14,  num:11'd2, rdy_pat:16'hFFFF, exp_addr:'{14, 15, 0, 0, 0, 0, 0, 0}};

    // Reset values
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst cmd_ready",  512'(cmd_ready),  512'(0));
    check("rst fold_valid", 512'(fold_valid), 512'(0));
    check("rst fold_data",  512'(fold_data),  512'(0));
    check("rst fold_idx",   512'(fold_idx),   512'(0));
    check("rst fold_last",  512'(fold_last),  512'(0));
    check("rst busy",       512'(busy),       512'(0));
    check("rst im_addr",    512'(im_addr),    512'(0));
    check("rst we",         512'(we),         512'(1));
`ifdef IM_FOLD_PARITY_EN
    check("rst fold_parity", 512'(fold_parity), 512'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post-rst cmd_ready", 512'(cmd_ready), 512'(1));

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Reset while one fold is buffered and one read is in flight
    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_base_addr = 10'd200;
    cmd_num_folds = 11'd8;
    fold_ready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst buffered before", 512'(fold_valid), 512'(1));
    check("midrst we",              512'(we),         512'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst fold_valid", 512'(fold_valid), 512'(0));
    check("midrst busy",       512'(busy),       512'(0));
    check("midrst cmd_ready",  512'(cmd_ready),  512'(0));
    check("midrst fold_data",  512'(fold_data),  512'(0));
    @(negedge clk);
    check("midrst discard",    512'(fold_valid), 512'(0));
    check("midrst ready back", 512'(cmd_ready),  512'(1));
    v2 = '{name:"after_rst", base:10'd0, num:11'd2, rdy_pat:16'hFFFF, exp_addr:'{0, 1, 0, 0, 0, 0, 0, 0}};
    run_cmd(v2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
